berzerk_dl_ctrl: RTL and testbench
==================================

# berzerk_dl_ctrl

ROM-download and core-reset sequencer that sits between `hps_io` and the `berzerk` core. It owns the ioctl download stream and decodes each byte into a program-ROM or speech-ROM write strobe. It holds the core in reset during power-up, downloads and user reset requests, then releases it after a programmable hold time. It also reports byte count, overflow and an optional running checksum to the top level.

## Interface
Parameters:
- `PROG_END`, 16'h2FFF: last byte address of the program-ROM region; the region starts at 0.
- `SPEECH_END`, 16'h3FFF: last byte address of the speech-ROM region, which starts at `PROG_END+1`.
- `RST_HOLD`, 1024: number of cycles `core_reset` stays high after a hold starts; legal range 1..65535.

Ports:
- `clk_sys` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download window.
- `ioctl_wr` in 1: byte-valid strobe, one cycle per byte.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `rst_req` in 1: level user reset request (status[0] | buttons[1]).
- `prog_we` out 1: program-ROM write pulse.
- `speech_we` out 1: speech-ROM write pulse.
- `wr_addr` out 16: region-relative write address.
- `wr_data` out 8: write data.
- `core_reset` out 1: active-high reset to the core.
- `busy` out 1: high in any state other than RUN.
- `dl_bytes` out 16: count of accepted bytes in the current or last download; saturates at FFFF.
- `dl_ovf` out 1: sticky; a byte arrived with address > `SPEECH_END`.
- `checksum` out 8: running sum of accepted bytes.

## Operation
- States: POR, LOAD, HOLD, RUN.
- Async reset values: state=POR, hold counter=0, `core_reset`=1, `busy`=1, `prog_we`=`speech_we`=0, `wr_addr`=0, `wr_data`=0, `dl_bytes`=0, `dl_ovf`=0, `checksum`=0.
- POR: counts `RST_HOLD` cycles, then goes to RUN.
- RUN: `core_reset`=0. A rising edge of `ioctl_download` moves to LOAD. Otherwise `rst_req`=1 moves to HOLD with the counter cleared.
- LOAD: `core_reset`=1.
  - Entering LOAD clears `dl_bytes`, `dl_ovf` and `checksum`.
  - When `ioctl_download` is sampled low, go to HOLD with the counter cleared.
- HOLD: `core_reset`=1. Counts to `RST_HOLD`, then goes to RUN.
  - Download rising edge in HOLD or POR moves to LOAD, which has priority over counting.
  - `rst_req` held high keeps the counter at 0.
- Byte decode applies when `ioctl_wr`=1 and state is LOAD:
  - addr <= `PROG_END`: `prog_we`, `wr_addr`=addr.
  - addr in `PROG_END+1`..`SPEECH_END`: `speech_we`, `wr_addr`=addr-`PROG_END`-1.
  - Otherwise no strobe; set `dl_ovf`. Address bits 24:16 nonzero also count as overflow.
  - Accepted bytes increment `dl_bytes` and add to `checksum` modulo 256.
- `ioctl_wr` outside LOAD is ignored completely.
- A download edge is detected from the registered previous value of `ioctl_download`. A download already high when `reset_n` releases is treated as a rising edge on the first cycle.

## Timing
- Write strobes, `wr_addr` and `wr_data` are registered: 1-cycle latency from `ioctl_wr`, 1-cycle pulse width. Back-to-back `ioctl_wr` yields back-to-back strobes.
- `dl_bytes`, `dl_ovf` and `checksum` update on the same edge as the strobe.
- If `ioctl_wr` and the falling edge of `ioctl_download` arrive on the same cycle, the byte is accepted and its strobe still issues.
- Let cycle F be the first cycle `ioctl_download` is sampled low in LOAD.
  - HOLD is active from F+1.
  - `core_reset` and `busy` fall on the edge that ends F+`RST_HOLD`, so they are first low in cycle F+1+`RST_HOLD`.
- `core_reset` rises on the cycle after the download rising edge or the `rst_req` sample in RUN.
- `reset_n` asserted mid-download aborts immediately to POR values. Partially written ROM is not re-validated.

## Configuration
- `DL_CHECKSUM_EN` defined: the checksum adder is compiled in and `checksum` behaves as above.
- `DL_CHECKSUM_EN` not defined: no adder; `checksum` is tied to 8'h00.

## Test plan
- POR: release `reset_n` with `RST_HOLD`=16 -> `core_reset`=1 for exactly 16 cycles, then 0; `busy` tracks `core_reset`.
- Full load: stream bytes 0x00..0x3FFF, data = addr[7:0] -> 12288 `prog_we` and 4096 `speech_we` pulses.
  - First speech pulse has `wr_addr`=0; `dl_bytes`=0x4000; `checksum`=0x00 (64 × 0x80 × 255 mod 256); `dl_ovf`=0.
- Overflow: one byte at addr 0x4000 -> no strobe, `dl_ovf`=1, `dl_bytes` unchanged. A new download clears `dl_ovf`.
- Edge coincidence: last `ioctl_wr` on the same cycle `ioctl_download` falls -> strobe issued. `core_reset` is first low exactly F+1+`RST_HOLD`.
- Re-entry: raise `ioctl_download` midway through HOLD -> state goes to LOAD, counters clear, `core_reset` stays 1 throughout.
- User reset: pulse `rst_req` for 3 cycles in RUN -> `core_reset` high for 3+`RST_HOLD` cycles (±1). `ioctl_wr` during this time produces no strobe.

Source files
------------

// File: rtl/berzerk_dl_ctrl.sv
// berzerk_dl_ctrl
//   ROM-download and core-reset sequencer between hps_io and the berzerk core.
//   Decodes the ioctl byte stream into program-ROM / speech-ROM write strobes,
//   holds the core in reset during power-up, downloads and user reset requests,
//   and reports byte count, overflow and an optional running checksum.
//
//   Optional feature macro: DL_CHECKSUM_EN
//     defined     -> running 8-bit sum of accepted bytes on `checksum`
//     not defined -> no adder, `checksum` tied to 8'h00
//
// Ports
//   clk_sys         single clock
//   reset_n         asynchronous active-low reset
//   ioctl_download  download window
//   ioctl_wr        byte strobe (one cycle per byte)
//   ioctl_addr      byte address (25 bits)
//   ioctl_dout      byte data
//   rst_req         level user reset request
//   prog_we         program-ROM write pulse (registered)
//   speech_we       speech-ROM write pulse (registered)
//   wr_addr         region-relative write address
//   wr_data         write data
//   core_reset      active-high reset to the core
//   busy            high in every state except RUN
//   dl_bytes        accepted bytes in current/last download, saturating
//   dl_ovf          sticky: a byte was addressed beyond SPEECH_END
//   checksum        running sum of accepted bytes (see macro above)

module berzerk_dl_ctrl #(
   parameter logic [15:0] PROG_END   = 16'h2FFF,
   parameter logic [15:0] SPEECH_END = 16'h3FFF,
   parameter int unsigned RST_HOLD   = 1024
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        rst_req,
   output logic        prog_we,
   output logic        speech_we,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        core_reset,
   output logic        busy,
   output logic [15:0] dl_bytes,
   output logic        dl_ovf,
   output logic [7:0]  checksum
);

   typedef enum logic [1:0] {
      ST_POR  = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2,
      ST_RUN  = 2'd3
   } state_t;

   localparam logic [15:0] HOLD_LAST   = 16'(RST_HOLD - 1);
   localparam logic [15:0] SPEECH_BASE = PROG_END + 16'd1;

   state_t      state;
   logic [15:0] hold_cnt;
   // Resets to 0 so a download already high at reset release looks like a rising edge.
   logic        dl_prev;

   logic        dl_rise;
   logic        load_enter;
   logic [15:0] addr_lo;
   logic        addr_hi_nz;
   logic        in_prog;
   logic        in_speech;
   logic        byte_acc;
   logic        byte_ok;

   assign dl_rise    = ioctl_download & ~dl_prev;
   // LOAD can only be entered from POR/HOLD/RUN; a rise while already in LOAD cannot occur.
   assign load_enter = dl_rise && (state != ST_LOAD);
   assign addr_lo    = ioctl_addr[15:0];
   assign addr_hi_nz = |ioctl_addr[24:16];
   assign in_prog    = !addr_hi_nz && (addr_lo <= PROG_END);
   assign in_speech  = !addr_hi_nz && !in_prog && (addr_lo <= SPEECH_END);
   assign byte_acc   = ioctl_wr && (state == ST_LOAD);
   assign byte_ok    = byte_acc && (in_prog || in_speech);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_POR;
         hold_cnt   <= 16'd0;
         dl_prev    <= 1'b0;
         core_reset <= 1'b1;
         busy       <= 1'b1;
         prog_we    <= 1'b0;
         speech_we  <= 1'b0;
         wr_addr    <= 16'd0;
         wr_data    <= 8'd0;
         dl_bytes   <= 16'd0;
         dl_ovf     <= 1'b0;
      end else begin
         dl_prev   <= ioctl_download;
         prog_we   <= 1'b0;
         speech_we <= 1'b0;

         // Byte decode; still active on the cycle the download window closes.
         if (byte_acc) begin
            if (in_prog) begin
               prog_we <= 1'b1;
               wr_addr <= addr_lo;
               wr_data <= ioctl_dout;
            end else if (in_speech) begin
               speech_we <= 1'b1;
               wr_addr   <= addr_lo - SPEECH_BASE;
               wr_data   <= ioctl_dout;
            end else begin
               dl_ovf <= 1'b1;
            end
            if (byte_ok && (dl_bytes != 16'hFFFF))
               dl_bytes <= dl_bytes + 16'd1;
         end

         if (load_enter) begin
            dl_bytes <= 16'd0;
            dl_ovf   <= 1'b0;
         end

         case (state)
            ST_POR, ST_HOLD: begin
               if (dl_rise) begin
                  state    <= ST_LOAD;
                  hold_cnt <= 16'd0;
               end else if ((state == ST_HOLD) && rst_req) begin
                  hold_cnt <= 16'd0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state      <= ST_RUN;
                  hold_cnt   <= 16'd0;
                  core_reset <= 1'b0;
                  busy       <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + 16'd1;
               end
            end
            ST_LOAD: begin
               if (!ioctl_download) begin
                  state    <= ST_HOLD;
                  hold_cnt <= 16'd0;
               end
            end
            ST_RUN: begin
               if (dl_rise) begin
                  state      <= ST_LOAD;
                  core_reset <= 1'b1;
                  busy       <= 1'b1;
               end else if (rst_req) begin
                  state      <= ST_HOLD;
                  hold_cnt   <= 16'd0;
                  core_reset <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            default: begin
               state      <= ST_POR;
               hold_cnt   <= 16'd0;
               core_reset <= 1'b1;
               busy       <= 1'b1;
            end
         endcase
      end
   end

`ifdef DL_CHECKSUM_EN
   logic [7:0] sum;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         sum <= 8'd0;
      else if (load_enter)
         sum <= 8'd0;
      else if (byte_ok)
         sum <= sum + ioctl_dout;
   end

   assign checksum = sum;
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_berzerk_dl_ctrl.sv
module tb_berzerk_dl_ctrl;

   localparam int unsigned RST_HOLD = 16;
`ifdef DL_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        rst_req;
   logic        prog_we;
   logic        speech_we;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        core_reset;
   logic        busy;
   logic [15:0] dl_bytes;
   logic        dl_ovf;
   logic [7:0]  checksum;

   int vectors     = 0;
   int miscompares = 0;
   int prog_cnt    = 0;
   int speech_cnt  = 0;

   berzerk_dl_ctrl #(
      .PROG_END  (16'h2FFF),
      .SPEECH_END(16'h3FFF),
      .RST_HOLD  (RST_HOLD)
   ) dut (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .ioctl_download(ioctl_download),
      .ioctl_wr      (ioctl_wr),
      .ioctl_addr    (ioctl_addr),
      .ioctl_dout    (ioctl_dout),
      .rst_req       (rst_req),
      .prog_we       (prog_we),
      .speech_we     (speech_we),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .core_reset    (core_reset),
      .busy          (busy),
      .dl_bytes      (dl_bytes),
      .dl_ovf        (dl_ovf),
      .checksum      (checksum)
   );

   always #5 clk_sys = ~clk_sys;

   // Strobe counters sampled on the falling edge, one sample per cycle.
   always @(negedge clk_sys) begin
      if (prog_we === 1'b1)   prog_cnt   <= prog_cnt + 1;
      if (speech_we === 1'b1) speech_cnt <= speech_cnt + 1;
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // One byte write; outputs are checked by the caller right after the edge.
   task automatic do_wr(input logic [24:0] a, input logic [7:0] d);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   // Counts edges until core_reset drops; returns the count (bounded).
   task automatic wait_release(output int n);
      n = 0;
      while (core_reset === 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      rst_req        = 1'b0;
      repeat (3) tick();
      vectors++;
      if ({core_reset, busy, prog_we, speech_we, wr_addr, wr_data, dl_bytes, dl_ovf, checksum}
          !== {1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 16'h0, 1'b0, 8'h0}) begin
         miscompares++;
         $display("FAIL reset_values: got cr=%b busy=%b pw=%b sw=%b wa=%h wd=%h bytes=%h ovf=%b cs=%h, want 1 1 0 0 0000 00 0000 0 00",
                  core_reset, busy, prog_we, speech_we, wr_addr, wr_data, dl_bytes, dl_ovf, checksum);
      end
      reset_n = 1'b1;
      n = 0;
      while (core_reset === 1'b1 && n < 200) begin
         vectors++;
         if (busy !== core_reset) begin
            miscompares++;
            $display("FAIL por_busy_track: busy=%b core_reset=%b at edge %0d", busy, core_reset, n);
         end
         tick();
         n++;
      end
      vectors++;
      if (n != RST_HOLD) begin
         miscompares++;
         $display("FAIL por_hold_len: got %0d cycles, want %0d", n, RST_HOLD);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL por_busy_low: got %b, want 0", busy);
      end
      $display("reset: core_reset high %0d cycles after release", n);
   endtask

   task automatic test_full_load();
      int n;
      int p0, s0;
      logic [7:0] sum;
      logic [15:0] a16;
      p0  = prog_cnt;
      s0  = speech_cnt;
      sum = 8'h00;
      ioctl_download = 1'b1;
      tick();
      vectors++;
      if (core_reset !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL load_enter_reset: cr=%b busy=%b, want 1 1", core_reset, busy);
      end
      for (int a = 0; a < 16384; a++) begin
         a16 = 16'(a);
         ioctl_wr   = 1'b1;
         ioctl_addr = {9'd0, a16};
         ioctl_dout = a16[7:0];
         if (a == 16383) ioctl_download = 1'b0;   // edge coincidence on last byte
         tick();
         sum = sum + a16[7:0];
         if (a == 0 || a == 16'h2FFF) begin
            vectors++;
            if ({prog_we, speech_we, wr_addr, wr_data} !== {1'b1, 1'b0, a16, a16[7:0]}) begin
               miscompares++;
               $display("FAIL prog_strobe@%h: pw=%b sw=%b wa=%h wd=%h, want 1 0 %h %h",
                        a16, prog_we, speech_we, wr_addr, wr_data, a16, a16[7:0]);
            end
         end
         if (a == 16'h3000) begin
            vectors++;
            if ({prog_we, speech_we, wr_addr, wr_data} !== {1'b0, 1'b1, 16'h0000, 8'h00}) begin
               miscompares++;
               $display("FAIL first_speech: pw=%b sw=%b wa=%h wd=%h, want 0 1 0000 00",
                        prog_we, speech_we, wr_addr, wr_data);
            end
         end
      end
      ioctl_wr = 1'b0;
      vectors++;
      if ({speech_we, wr_addr, wr_data} !== {1'b1, 16'h0FFF, 8'hFF}) begin
         miscompares++;
         $display("FAIL last_byte_on_fall: sw=%b wa=%h wd=%h, want 1 0fff ff", speech_we, wr_addr, wr_data);
      end
      vectors++;
      if (dl_bytes !== 16'h4000 || dl_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL full_load_stats: bytes=%h ovf=%b, want 4000 0", dl_bytes, dl_ovf);
      end
      vectors++;
      if (checksum !== (CSUM_ON ? sum : 8'h00)) begin
         miscompares++;
         $display("FAIL full_load_checksum: got %h, want %h", checksum, CSUM_ON ? sum : 8'h00);
      end
      wait_release(n);
      vectors++;
      if (n != RST_HOLD) begin
         miscompares++;
         $display("FAIL fall_to_release: got %0d edges after F, want %0d", n, RST_HOLD);
      end
      tick();
      vectors++;
      if ((prog_cnt - p0) != 12288 || (speech_cnt - s0) != 4096) begin
         miscompares++;
         $display("FAIL strobe_counts: prog=%0d speech=%0d, want 12288 4096", prog_cnt - p0, speech_cnt - s0);
      end
      $display("full_load: prog=%0d speech=%0d bytes=%h cs=%h release=%0d",
               prog_cnt - p0, speech_cnt - s0, dl_bytes, checksum, n);
   endtask

   task automatic test_overflow_reentry();
      int n;
      logic cr_ok;
      ioctl_download = 1'b1;
      tick();
      do_wr(25'h0000010, 8'h5A);
      vectors++;
      if (prog_we !== 1'b1 || dl_bytes !== 16'd1) begin
         miscompares++;
         $display("FAIL ovf_prebyte: pw=%b bytes=%h, want 1 0001", prog_we, dl_bytes);
      end
      do_wr(25'h0004000, 8'h77);
      vectors++;
      if ({prog_we, speech_we, dl_ovf, dl_bytes} !== {1'b0, 1'b0, 1'b1, 16'd1}) begin
         miscompares++;
         $display("FAIL ovf_4000: pw=%b sw=%b ovf=%b bytes=%h, want 0 0 1 0001", prog_we, speech_we, dl_ovf, dl_bytes);
      end
      do_wr(25'h0010005, 8'h11);
      vectors++;
      if ({prog_we, speech_we, dl_ovf, dl_bytes} !== {1'b0, 1'b0, 1'b1, 16'd1}) begin
         miscompares++;
         $display("FAIL ovf_highbits: pw=%b sw=%b ovf=%b bytes=%h, want 0 0 1 0001", prog_we, speech_we, dl_ovf, dl_bytes);
      end
      vectors++;
      if (checksum !== (CSUM_ON ? 8'h5A : 8'h00)) begin
         miscompares++;
         $display("FAIL ovf_checksum: got %h, want %h", checksum, CSUM_ON ? 8'h5A : 8'h00);
      end
      $display("overflow: ovf=%b bytes=%h cs=%h", dl_ovf, dl_bytes, checksum);
      // Close the window, sit part way through HOLD, then re-open.
      ioctl_download = 1'b0;
      cr_ok = 1'b1;
      repeat (8) begin
         tick();
         if (core_reset !== 1'b1) cr_ok = 1'b0;
      end
      ioctl_download = 1'b1;
      tick();
      if (core_reset !== 1'b1) cr_ok = 1'b0;
      vectors++;
      if (cr_ok !== 1'b1) begin
         miscompares++;
         $display("FAIL reentry_core_reset: core_reset dropped during HOLD/re-entry, want held 1");
      end
      vectors++;
      if ({dl_ovf, dl_bytes, checksum} !== {1'b0, 16'd0, 8'd0}) begin
         miscompares++;
         $display("FAIL reentry_clear: ovf=%b bytes=%h cs=%h, want 0 0000 00", dl_ovf, dl_bytes, checksum);
      end
      do_wr(25'h0003005, 8'hC3);
      vectors++;
      if ({speech_we, wr_addr, wr_data, dl_bytes} !== {1'b1, 16'h0005, 8'hC3, 16'd1}) begin
         miscompares++;
         $display("FAIL reentry_speech: sw=%b wa=%h wd=%h bytes=%h, want 1 0005 c3 0001", speech_we, wr_addr, wr_data, dl_bytes);
      end
      ioctl_download = 1'b0;
      tick();
      wait_release(n);
      vectors++;
      if (n != RST_HOLD) begin
         miscompares++;
         $display("FAIL reentry_hold_len: got %0d, want %0d", n, RST_HOLD);
      end
      $display("reentry: bytes=%h release=%0d", dl_bytes, n);
   endtask

   task automatic test_user_reset();
      int n;
      logic strobe_seen;
      strobe_seen = 1'b0;
      rst_req    = 1'b1;
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h0000100;
      ioctl_dout = 8'hEE;
      tick();
      vectors++;
      if (core_reset !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL user_reset_rise: cr=%b busy=%b, want 1 1", core_reset, busy);
      end
      n = 0;
      while (core_reset === 1'b1 && n < 200) begin
         if (n == 2) rst_req = 1'b0;
         if (prog_we !== 1'b0 || speech_we !== 1'b0) strobe_seen = 1'b1;
         tick();
         n++;
      end
      ioctl_wr = 1'b0;
      vectors++;
      if (n != RST_HOLD + 2) begin
         miscompares++;
         $display("FAIL user_reset_len: got %0d cycles, want %0d", n, RST_HOLD + 2);
      end
      vectors++;
      if (strobe_seen !== 1'b0 || dl_bytes !== 16'd1) begin
         miscompares++;
         $display("FAIL user_reset_wr_ignored: strobe=%b bytes=%h, want 0 0001", strobe_seen, dl_bytes);
      end
      $display("user_reset: core_reset high %0d cycles", n);
   endtask

   task automatic test_abort();
      int n;
      ioctl_download = 1'b1;
      tick();
      do_wr(25'h0000020, 8'h44);
      vectors++;
      if (dl_bytes !== 16'd1) begin
         miscompares++;
         $display("FAIL abort_prebyte: bytes=%h, want 0001", dl_bytes);
      end
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({dl_bytes, core_reset, busy, wr_addr} !== {16'd0, 1'b1, 1'b1, 16'd0}) begin
         miscompares++;
         $display("FAIL abort_async: bytes=%h cr=%b busy=%b wa=%h, want 0000 1 1 0000", dl_bytes, core_reset, busy, wr_addr);
      end
      tick();
      reset_n = 1'b1;            // download still high: first cycle counts as a rise
      tick();
      do_wr(25'h0000000, 8'h99);
      vectors++;
      if ({prog_we, wr_data, dl_bytes, core_reset} !== {1'b1, 8'h99, 16'd1, 1'b1}) begin
         miscompares++;
         $display("FAIL high_at_release: pw=%b wd=%h bytes=%h cr=%b, want 1 99 0001 1", prog_we, wr_data, dl_bytes, core_reset);
      end
      ioctl_download = 1'b0;
      tick();
      wait_release(n);
      vectors++;
      if (n != RST_HOLD) begin
         miscompares++;
         $display("FAIL abort_release: got %0d, want %0d", n, RST_HOLD);
      end
      $display("abort: reload bytes=%h release=%0d", dl_bytes, n);
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_overflow_reentry();
      test_user_reset();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
